// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - fixed-latency word memory responder for the MEM-stage load/store port
module data_memory_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic             perform;
    logic             acc_we;
    logic             acc_err;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] acc_idx;

    // With a single-cycle latency the access happens on the accept edge, straight from the request fields.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        perform   = 1'b0;
        if (state == IDLE) begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
            perform   = req_i && (LATENCY == 1);
        end else if (state == BUSY) begin
            perform   = (cnt == 4'd0);
        end
        acc_err = (acc_addr[1:0] != 2'b00) ||
                  ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
        acc_idx = acc_addr[IDX_W+1:2];
    end

    assign stall_o = ((state == IDLE) && req_i) || (state == BUSY);

    always_ff @(posedge clk_i) begin
        if (!rst_i && perform && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= 32'd0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
        end else begin
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            rdata_o <= 32'd0;
            if (perform) begin
                ack_o <= 1'b1;
                err_o <= acc_err;
                if (!acc_err && !acc_we) begin
                    rdata_o <= mem[acc_idx];
                end
            end
            case (state)
                IDLE: begin
                    if (req_i) begin
                        lat_we    <= we_i;
                        lat_addr  <= addr_i;
                        lat_wdata <= wdata_i;
                        if (LATENCY == 1) begin
                            state <= DONE;
                        end else begin
                            cnt   <= 4'(LATENCY - 2);
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - directed bench for data_memory_responder at LATENCY 3 and 1
module tb_data_memory_responder;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = '0;
    logic [1:0]       we = '0;
    logic [1:0][31:0] addr = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][31:0] rdata;
    logic [1:0]       ack;
    logic [1:0]       err;
    logic [1:0]       stall;
    int               cyc = 0;
    int               vecs = 0;
    int               errs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_o(stall[0])
    );

    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_o(stall[1])
    );

    // One request on DUT d, held until ack; optionally swaps addr_i to chg_a in cycle chg_i after accept.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input int chg_i, input logic [31:0] chg_a,
                        output logic [31:0] rd, output logic e, output int lat,
                        output int nstall, output logic sack, output int start);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        lat = -1; nstall = 0; rd = '0; e = 1'b0; sack = 1'b0; start = cyc;
        for (int i = 0; i < 40; i++) begin
            if (i == chg_i && i > 0) addr[d] = chg_a;
            #1;
            if (ack[d]) begin
                lat = i; rd = rdata[d]; e = err[d]; sack = stall[d];
                break;
            end
            if (stall[d]) nstall++;
            @(negedge clk);
        end
        req[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vecs++; if ({ack, err, stall} !== 6'b0) begin errs++; $display("FAIL reset_flags got %b exp 000000", {ack, err, stall}); end
        vecs++; if (rdata[0] !== 32'd0 || rdata[1] !== 32'd0) begin errs++; $display("FAIL reset_rdata got %h/%h exp 0", rdata[0], rdata[1]); end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e, sa; int lat, ns, s0, s1;
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 0, rd, e, lat, ns, sa, s0);
        vecs++; if (lat !== 3) begin errs++; $display("FAIL st_lat got %0d exp 3", lat); end
        vecs++; if (ns !== 3 || sa !== 1'b0) begin errs++; $display("FAIL st_stall got %0d/%b exp 3/0", ns, sa); end
        vecs++; if (e !== 1'b0 || rd !== 32'd0) begin errs++; $display("FAIL st_resp got %b/%h exp 0/0", e, rd); end
        xfer(0, 1'b0, 32'h10, 32'h0, 0, 0, rd, e, lat, ns, sa, s1);
        vecs++; if (s1 - s0 !== 4) begin errs++; $display("FAIL ld_start got %0d exp 4", s1 - s0); end
        vecs++; if (lat !== 3 || e !== 1'b0) begin errs++; $display("FAIL ld_lat got %0d/%b exp 3/0", lat, e); end
        vecs++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL ld_rdata got %h exp deadbeef", rd); end
    endtask

    task automatic test_latency1();
        logic [31:0] rd; logic e, sa; int lat, ns, st, prev;
        for (int k = 0; k < 3; k++) xfer(1, 1'b1, 32'(4 * k), 32'hA0 + 32'(k), 0, 0, rd, e, lat, ns, sa, st);
        prev = 0;
        for (int k = 0; k < 3; k++) begin
            xfer(1, 1'b0, 32'(4 * k), 32'h0, 0, 0, rd, e, lat, ns, sa, st);
            vecs++; if (lat !== 1 || ns !== 1 || sa !== 1'b0) begin errs++; $display("FAIL l1_timing[%0d] got lat %0d stall %0d/%b exp 1 1/0", k, lat, ns, sa); end
            vecs++; if (rd !== 32'hA0 + 32'(k) || e !== 1'b0) begin errs++; $display("FAIL l1_rdata[%0d] got %h/%b exp %h/0", k, rd, e, 32'hA0 + 32'(k)); end
            if (k > 0) begin
                vecs++; if (st - prev !== 2) begin errs++; $display("FAIL l1_spacing[%0d] got %0d exp 2", k, st - prev); end
            end
            prev = st;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic e, sa; int lat, ns, st;
        xfer(0, 1'b1, 32'h12, 32'h12345678, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (lat !== 3 || e !== 1'b1 || rd !== 32'd0) begin errs++; $display("FAIL mis_st got lat %0d err %b rd %h exp 3 1 0", lat, e, rd); end
        xfer(0, 1'b0, 32'h10, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errs++; $display("FAIL mis_keep got %h/%b exp deadbeef/0", rd, e); end
        xfer(0, 1'b0, 32'h13, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (e !== 1'b1 || rd !== 32'd0) begin errs++; $display("FAIL mis_ld got %b/%h exp 1/0", e, rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic e, sa; int lat, ns, st;
        xfer(0, 1'b1, 32'h3FC, 32'h5A5A00FF, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (e !== 1'b0) begin errs++; $display("FAIL oor_st255 err got %b exp 0", e); end
        xfer(0, 1'b0, 32'h400, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (e !== 1'b1 || rd !== 32'd0 || lat !== 3) begin errs++; $display("FAIL oor_400 got %b/%h/%0d exp 1/0/3", e, rd, lat); end
        xfer(0, 1'b0, 32'h3FC, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (e !== 1'b0 || rd !== 32'h5A5A00FF) begin errs++; $display("FAIL oor_3fc got %b/%h exp 0/5a5a00ff", e, rd); end
        xfer(0, 1'b0, 32'h80000010, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (e !== 1'b1 || rd !== 32'd0) begin errs++; $display("FAIL oor_alias got %b/%h exp 1/0", e, rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e, sa; int lat, ns, st, acks, stalls;
        xfer(0, 1'b1, 32'h20, 32'h11112222, 0, 0, rd, e, lat, ns, sa, st);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        vecs++; if (stall[0] !== 1'b1) begin errs++; $display("FAIL rst_busy stall got %b exp 1", stall[0]); end
        rst = 1'b1; req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acks = 0; stalls = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (ack[0]) acks++;
            if (stall[0]) stalls++;
            @(negedge clk);
        end
        vecs++; if (acks !== 0 || stalls !== 0) begin errs++; $display("FAIL rst_abort got acks %0d stalls %0d exp 0 0", acks, stalls); end
        xfer(0, 1'b0, 32'h20, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (rd !== 32'h11112222 || e !== 1'b0) begin errs++; $display("FAIL rst_nowrite got %h/%b exp 11112222/0", rd, e); end
    endtask

    task automatic test_field_change();
        logic [31:0] rd; logic e, sa; int lat, ns, st;
        xfer(0, 1'b1, 32'h14, 32'h14141414, 0, 0, rd, e, lat, ns, sa, st);
        xfer(0, 1'b1, 32'h10, 32'h0BADF00D, 1, 32'h14, rd, e, lat, ns, sa, st);
        vecs++; if (lat !== 3 || e !== 1'b0) begin errs++; $display("FAIL chg_st got %0d/%b exp 3/0", lat, e); end
        xfer(0, 1'b0, 32'h10, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (rd !== 32'h0BADF00D) begin errs++; $display("FAIL chg_10 got %h exp 0badf00d", rd); end
        xfer(0, 1'b0, 32'h14, 32'h0, 0, 0, rd, e, lat, ns, sa, st);
        vecs++; if (rd !== 32'h14141414) begin errs++; $display("FAIL chg_14 got %h exp 14141414", rd); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_latency1();
        test_misaligned();
        test_out_of_range();
        test_reset_mid();
        test_field_change();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Memory-side responder for the pipelined CPU's MEM-stage load/store port: accepts one word request, holds the pipeline with stall_o for a fixed latency, then completes with a one-cycle ack_o.
- Replaces the ideal single-cycle data memory, so the pipeline's stall path is exercised under realistic multi-cycle access.
- Backed by an internal word-addressed RAM array.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; valid word index range is 0..DEPTH_WORDS-1.
- LATENCY, 3, cycles from request-accept cycle to ack cycle; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state changes on its rising edge
- rst_i  input  1  reset; synchronous, active-high
- req_i  input  1  request valid; the CPU holds this and all request fields stable until the ack cycle
- we_i  input  1  1 = store word, 0 = load word
- addr_i  input  32  byte address
- wdata_i  input  32  store data
- rdata_o  output  32  load data; valid only in the ack cycle
- ack_o  output  1  one-cycle completion pulse
- err_o  output  1  with ack_o: misaligned or out-of-range access
- stall_o  output  1  pipeline freeze request (combinational)

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, counter=0, ack_o=0, err_o=0, rdata_o=0. Array contents are not reset.
- Reset has priority over every other event. Reset in BUSY aborts the request: a pending store is discarded and no ack is issued.
- States: IDLE, BUSY, DONE.
- IDLE, req_i=0: stay in IDLE.
- IDLE, req_i=1 (accept cycle t): latch we_i, addr_i and wdata_i.
  - LATENCY=1: perform the access at this edge and go to DONE.
  - LATENCY>=2: load counter with LATENCY-2 and go to BUSY.
- BUSY:
  - counter>0: decrement.
  - counter=0: perform the access at this edge using the latched fields, then go to DONE.
- DONE: ack_o=1 for exactly this cycle (cycle t+LATENCY); then go to IDLE unconditionally.
  - req_i in the DONE cycle belongs to the completing request and is not re-accepted.
  - The next request is sampled in the following IDLE cycle, so back-to-back requests have no dead cycle beyond LATENCY.
- ack_o, err_o and rdata_o are registered and are 0 in every cycle outside DONE.
- stall_o = (state==IDLE and req_i) or state==BUSY. It is 0 in DONE, which lets the pipeline advance on the ack edge.
- Access at the perform edge (word index = addr[31:2]):
  - Error check: error when addr[1:0]!=0, or when the word index is >= DEPTH_WORDS. Compare the full upper address bits; no wrap-around or aliasing.
  - Error: no array write, rdata_o=0, err_o=1.
  - Store: array[index] is written with wdata; rdata_o=0; err_o=0.
  - Load: rdata_o is set to array[index] (the value before any write at this edge); err_o=0.
- Request fields that change after the accept cycle are ignored; the latched copies are used.
- Width rules: the counter is 4 bits. DEPTH_WORDS need not be a power of two; the range check is still exact.

Test Plan:
- Store then load, LATENCY=3: store wdata=0xDEADBEEF to addr=0x10 (req accepted at t0) -> stall_o=1 at t0..t2, ack_o=1 at t3 with err_o=0. Load from 0x10 accepted at t4 -> ack_o at t7 with rdata_o=0xDEADBEEF.
- LATENCY=1 sweep: load 0x0, 0x4, 0x8, each held until ack -> each acked one cycle after accept, stall_o=1 only in the accept cycle, no extra idle cycles.
- Misaligned store to 0x12 with 0x12345678 -> ack_o=1 and err_o=1 at t+LATENCY, rdata_o=0. A following load of 0x10 returns its previous contents, unchanged.
- Out of range: with DEPTH_WORDS=256, load addr=0x400 -> err_o=1, rdata_o=0. Load addr=0x3FC -> err_o=0 and returns the array word 255.
- Reset mid-access: store 0xCAFEF00D to 0x20, assert rst_i for one cycle while in BUSY -> no ack_o ever issued, stall_o=0 after reset. A subsequent load of 0x20 returns the pre-store value.
- Request field change during BUSY: after accept, change addr_i from 0x10 to 0x14 -> the access uses 0x10.
